// File: rtl/rvc_asap_dmem_arb_pkg.sv
// rvc_asap_dmem_arb_pkg
//   Shared types and helpers for the multi-core D_MEM arbiter.
//   t_dmem_req / t_dmem_rsp describe one core's D_MEM channel at the
//   default 32-bit widths; ch_w() gives the channel-index width.
//   Build option: RVC_ASAP_ARB_RR_EN selects round-robin arbitration
//   (undefined = fixed priority, lowest index wins).
package rvc_asap_dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] data;
    logic [DMEM_ADDR_W-1:0] address;
    logic [DMEM_BE_W-1:0]   byteena;
    logic                   wren;
    logic                   rden;
  } t_dmem_req;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] q;
    logic                   valid;
  } t_dmem_rsp;

  // Channel index width; a single core still needs a 1-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvc_asap_dmem_arb_if.sv
// rvc_asap_dmem_arb_if
//   Bundles the core-side channels and the single D_MEM port.
//   slave  : arbiter view (core requests + q in, stalls/q/valids + mem port out)
//   master : cores/memory view (the opposite directions)
interface rvc_asap_dmem_arb_if #(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N_CORES-1:0][DATA_W-1:0] CoreData;
  logic [N_CORES-1:0][ADDR_W-1:0] CoreAddress;
  logic [N_CORES-1:0][BE_W-1:0]   CoreByteena;
  logic [N_CORES-1:0]             CoreWren;
  logic [N_CORES-1:0]             CoreRden;
  logic [N_CORES-1:0]             CoreStall;
  logic [DATA_W-1:0]              CoreQ;
  logic [N_CORES-1:0]             CoreQValid;

  logic [DATA_W-1:0]              data;
  logic [ADDR_W-1:0]              address;
  logic [BE_W-1:0]                byteena;
  logic                           wren;
  logic                           rden;
  logic [DATA_W-1:0]              q;

  modport slave (
    input  CoreData, CoreAddress, CoreByteena, CoreWren, CoreRden, q,
    output CoreStall, CoreQ, CoreQValid, data, address, byteena, wren, rden
  );

  modport master (
    output CoreData, CoreAddress, CoreByteena, CoreWren, CoreRden, q,
    input  CoreStall, CoreQ, CoreQValid, data, address, byteena, wren, rden
  );
endinterface

// File: rtl/rvc_asap_rr_arb.sv
// rvc_asap_rr_arb
//   Generic N-way combinational arbiter: one grant per cycle among req.
//   RVC_ASAP_ARB_RR_EN defined: search starts at ptr, wraps N-1 -> 0, and
//   ptr moves to (grant+1) mod N after each grant (held on idle cycles).
//   Undefined: fixed priority, lowest index wins, no pointer state.
//   Ports: Clock, Rst (sync, active low), req, gnt (one-hot), gnt_idx, gnt_vld.
module rvc_asap_rr_arb
  import rvc_asap_dmem_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int W = ch_w(N)
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

`ifdef RVC_ASAP_ARB_RR_EN
  logic [W-1:0] ptr;

  // Scan from the farthest position back to ptr so the closest requester
  // (highest priority) is the last one written.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) idx = (int'(ptr) + k) % N;
    end
    gnt_idx = W'(idx);
    if (gnt_vld) gnt[idx] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Rst)         ptr <= '0;
    else if (gnt_vld) ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) idx = k;
    end
    gnt_idx = W'(idx);
    if (gnt_vld) gnt[idx] = 1'b1;
  end

  // Fixed priority is stateless; clock and reset are intentionally unused.
  logic unused_clk_rst;
  assign unused_clk_rst = Clock ^ Rst;
`endif

endmodule

// File: rtl/rvc_asap_dmem_arb.sv
// rvc_asap_dmem_arb
//   Lets N_CORES cores share one D_MEM port. One request granted per cycle
//   (combinational, zero added latency); the granted channel drives the
//   memory, others see CoreStall. Reads return one cycle later on the
//   shared CoreQ with a one-hot CoreQValid tagging the owning core.
//   Ports: Clock, Rst (sync, active low), bus (rvc_asap_dmem_arb_if.slave).
//   Build option: RVC_ASAP_ARB_RR_EN = round-robin, else fixed priority.
module rvc_asap_dmem_arb
  import rvc_asap_dmem_arb_pkg::*;
#(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  localparam int CH_W   = ch_w(N_CORES)
) (
  input logic                Clock,
  input logic                Rst,
  rvc_asap_dmem_arb_if.slave bus
);

  logic [N_CORES-1:0] req;
  logic [N_CORES-1:0] gnt;
  logic [CH_W-1:0]    gnt_idx;
  logic               gnt_vld;
  logic               rsp_vld;
  logic [CH_W-1:0]    rsp_ch;

  assign req = bus.CoreWren | bus.CoreRden;

  rvc_asap_rr_arb #(.N(N_CORES)) u_arb (
    .Clock   (Clock),
    .Rst     (Rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign bus.CoreStall = req & ~gnt;

  // Memory port mux; write wins over a simultaneous read on one channel.
  always_comb begin
    bus.data    = '0;
    bus.address = '0;
    bus.byteena = '0;
    bus.wren    = 1'b0;
    bus.rden    = 1'b0;
    if (gnt_vld) begin
      bus.data    = bus.CoreData[gnt_idx];
      bus.address = bus.CoreAddress[gnt_idx];
      bus.byteena = bus.CoreByteena[gnt_idx];
      bus.wren    = bus.CoreWren[gnt_idx];
      bus.rden    = bus.CoreRden[gnt_idx] & ~bus.CoreWren[gnt_idx];
    end
  end

  // Response tag for the one-cycle memory read latency.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      rsp_vld <= 1'b0;
      rsp_ch  <= '0;
    end else begin
      rsp_vld <= bus.rden;
      rsp_ch  <= gnt_idx;
    end
  end

  assign bus.CoreQ = bus.q;

  // Gating with Rst drops a read that was in flight when reset arrived.
  always_comb begin
    bus.CoreQValid = '0;
    if (rsp_vld && Rst) bus.CoreQValid[rsp_ch] = 1'b1;
  end

endmodule

// File: tb/tb_rvc_asap_dmem_arb.sv
// tb_rvc_asap_dmem_arb
//   Directed scenarios plus randomized traffic against a behavioural
//   arbiter model (grant = first requester in search order).
module tb_rvc_asap_dmem_arb;
  import rvc_asap_dmem_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef RVC_ASAP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Rst;
  always #5 Clock = ~Clock;

  rvc_asap_dmem_arb_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rvc_asap_dmem_arb #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock (Clock),
    .Rst   (Rst),
    .bus   (bus)
  );

  t_dmem_req    creq [N];
  logic [DW-1:0] qv;
  int           mptr, pend_ch, last_g;
  bit           pend_vld;
  logic [N-1:0] last_stall;
  int           checks, errors;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) creq[i] = '0;
  endtask

  // One clock: drive at negedge, check against model, advance model state.
  task automatic cycle(input bit rst);
    logic [N-1:0] r, es;
    int           g;
    @(negedge Clock);
    Rst = rst;
    for (int i = 0; i < N; i++) begin
      bus.CoreData[i]    = creq[i].data;
      bus.CoreAddress[i] = creq[i].address;
      bus.CoreByteena[i] = creq[i].byteena;
      bus.CoreWren[i]    = creq[i].wren;
      bus.CoreRden[i]    = creq[i].rden;
      r[i]               = creq[i].wren | creq[i].rden;
    end
    bus.q = qv;
    #1;
    chk("qvalid", 64'(bus.CoreQValid), (pend_vld && rst) ? 64'(1 << pend_ch) : 64'(0));
    chk("coreq", 64'(bus.CoreQ), 64'(qv));
    g  = model_grant(r, mptr);
    es = r;
    if (g >= 0) es[g] = 1'b0;
    chk("stall", 64'(bus.CoreStall), 64'(es));
    if (g >= 0) begin
      chk("mem_wren", 64'(bus.wren), 64'(creq[g].wren));
      chk("mem_rden", 64'(bus.rden), 64'(creq[g].rden & ~creq[g].wren));
      chk("mem_addr", 64'(bus.address), 64'(creq[g].address));
      chk("mem_data", 64'(bus.data), 64'(creq[g].data));
      chk("mem_be", 64'(bus.byteena), 64'(creq[g].byteena));
    end else begin
      chk("idle_mem", {bus.wren, bus.rden, bus.byteena, bus.address, bus.data}, 64'(0));
    end
    last_g     = g;
    last_stall = es;
    if (!rst) begin
      mptr = 0; pend_vld = 0; pend_ch = 0;
    end else begin
      pend_vld = (g >= 0) && creq[g].rden && !creq[g].wren;
      pend_ch  = (g >= 0) ? g : 0;
      if (RR && g >= 0) mptr = (g + 1) % N;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    mptr = 0; pend_vld = 0; pend_ch = 0; last_stall = '0;
    qv = '0;
    clear_reqs();

    // Reset with every core reading: no valids, first grant goes to core 0.
    for (int i = 0; i < N; i++) creq[i].rden = 1'b1;
    cycle(0);
    chk("rst_qvalid", 64'(bus.CoreQValid), 64'(0));
    cycle(0);
    cycle(1);
    chk("rst_first_gnt", 64'(last_g), 64'(0));
    clear_reqs();
    cycle(1);

    // Single uncontended read from core 1.
    creq[1].rden = 1'b1; creq[1].address = 32'h1000;
    cycle(1);
    chk("single_stall", 64'(bus.CoreStall), 64'(0));
    clear_reqs(); qv = 32'hDEADBEEF;
    cycle(1);
    chk("single_qvalid", 64'(bus.CoreQValid), 64'(4'b0010));
    chk("single_q", 64'(bus.CoreQ), 64'(32'hDEADBEEF));

    // Cores 0 and 1 contend for four cycles.
    creq[0].rden = 1'b1; creq[0].address = 32'h40;
    creq[1].rden = 1'b1; creq[1].address = 32'h80;
    for (int k = 0; k < 4; k++) begin
      qv = $urandom;
      cycle(1);
      chk("cont_gnt", 64'(last_g), RR ? 64'(k % 2) : 64'(0));
    end
    clear_reqs();
    cycle(1);

    // Write and read on one channel: write wins, no read response.
    creq[0].wren = 1'b1; creq[0].rden = 1'b1; creq[0].byteena = 4'b0011;
    creq[0].data = 32'hCAFE_F00D; creq[0].address = 32'h200;
    cycle(1);
    chk("wr_rd_wren", 64'(bus.wren), 64'(1));
    chk("wr_rd_rden", 64'(bus.rden), 64'(0));
    clear_reqs();
    cycle(1);
    chk("wr_rd_noval", 64'(bus.CoreQValid), 64'(0));

    // Reset lands the cycle after a granted read.
    creq[2].rden = 1'b1;
    cycle(1);
    clear_reqs();
    cycle(0);
    chk("rst_mid_rd", 64'(bus.CoreQValid), 64'(0));
    cycle(1);
    chk("rst_mid_rd2", 64'(bus.CoreQValid), 64'(0));

    // Grant to the last core wraps the search back to core 0.
    creq[3].rden = 1'b1;
    cycle(1);
    chk("wrap_g3", 64'(last_g), 64'(3));
    creq[0].rden = 1'b1;
    cycle(1);
    chk("wrap_g0", 64'(last_g), 64'(0));
    clear_reqs();
    cycle(1);

    // Random traffic; stalled cores hold their request fields.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!last_stall[i]) begin
          creq[i] = '0;
          if ($urandom_range(0, 9) < 5) begin
            creq[i].data    = $urandom;
            creq[i].address = $urandom;
            creq[i].byteena = 4'($urandom);
            case ($urandom_range(0, 3))
              0:       creq[i].wren = 1'b1;
              1:       begin creq[i].wren = 1'b1; creq[i].rden = 1'b1; end
              default: creq[i].rden = 1'b1;
            endcase
          end
        end
      end
      qv = $urandom;
      cycle($urandom_range(0, 49) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
